em4100_tag_scheduler: RTL and testbench

Round-robin scheduler that shares one EM4100 emitter between N tag-ID requesters. It snapshots the granted requester's 40-bit ID and drives the emitter's `data`/`tx` inputs. Per grant it holds `tx` low for a load gap, then high for a fixed number of whole frames. It then acknowledges the requester and re-arbitrates. It sits between the host-side ID slots and the EM4100 emitter, and is the only driver of that emitter.

---
 rtl/em4100_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/em4100_tag_scheduler.sv | 121 ++++++++++++
 tb/tb_em4100_tag_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/em4100_pkg.sv
// Shared types and constants for the EM4100 tag scheduler.
package em4100_pkg;

    localparam int unsigned ID_W                 = 40;
    localparam int unsigned DEFAULT_FRAME_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requesting slot at or after ptr, modulo N.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(N);

    // Scan from the farthest slot down so the nearest one to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            automatic int slot = (int'(ptr) + k) % int'(N);
            if (req[IDX_W'(slot)]) begin
                valid = 1'b1;
                idx   = IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/em4100_tag_scheduler.sv
// Shares one EM4100 emitter among N ID slots: grant, load gap, fixed burst, ack.
module em4100_tag_scheduler
    import em4100_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
    parameter int unsigned REPEATS      = 3,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*ID_W-1:0]    id_flat,
    output logic [N-1:0]         ack,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 em_tx,
    output logic [ID_W-1:0]      em_data
);

    localparam int unsigned IDX_W       = $clog2(N);
    localparam int unsigned SEND_CYCLES = REPEATS * FRAME_CYCLES;
    localparam int unsigned CNT_W       = $clog2(SEND_CYCLES + 1);

    sched_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] next_ptr;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic [ID_W-1:0]  sel_id;
    logic             req_held;

    rr_arbiter #(.N(N)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    // ID of the slot the arbiter would grant this cycle.
    always_comb begin
        sel_id = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (arb_idx == IDX_W'(i)) sel_id = id_flat[i*ID_W +: ID_W];
        end
    end

    assign next_ptr = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign req_held = req[grant_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            grant_idx <= '0;
            em_tx     <= 1'b0;
            em_data   <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state     <= LOAD;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        grant_idx <= arb_idx;
                        em_data   <= sel_id;
                    end
                end
                LOAD: begin
                    if (!req_held) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        em_tx <= 1'b0;
                        ptr   <= next_ptr;
                    end else if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        state <= SEND;
                        cnt   <= '0;
                        em_tx <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SEND: begin
                    if (!req_held) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        em_tx <= 1'b0;
                        ptr   <= next_ptr;
                    end else if (cnt == CNT_W'(SEND_CYCLES - 1)) begin
                        state <= DONE;
                        cnt   <= '0;
                        em_tx <= 1'b0;
                        ack   <= N'(1) << grant_idx;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    ptr   <= next_ptr;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    em_tx <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_em4100_tag_scheduler.sv
// Directed bench for em4100_tag_scheduler (N=4, REPEATS=1, FRAME_CYCLES=64, GAP=2).
module tb_em4100_tag_scheduler;

    localparam int unsigned N       = 4;
    localparam int unsigned FRAME   = 64;
    localparam int unsigned REPEATS = 1;
    localparam int unsigned GAP     = 2;
    localparam int unsigned ACK_SEP = GAP + REPEATS * FRAME + 2;

    localparam logic [39:0] ID0     = 40'hA0_0000_0001;
    localparam logic [39:0] ID1     = 40'hB1_1111_2222;
    localparam logic [39:0] ID2     = 40'h12_3456_789A;
    localparam logic [39:0] ID3     = 40'hC3_DEAD_BEEF;
    localparam logic [39:0] ID0_NEW = 40'h5A_5A5A_5A5A;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*40-1:0] id_flat;
    logic [N-1:0]   ack;
    logic           busy;
    logic [1:0]     grant_idx;
    logic           em_tx;
    logic [39:0]    em_data;

    int passed = 0;
    int total  = 0;

    em4100_tag_scheduler #(
        .N(N), .FRAME_CYCLES(FRAME), .REPEATS(REPEATS), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .id_flat(id_flat),
        .ack(ack), .busy(busy), .grant_idx(grant_idx),
        .em_tx(em_tx), .em_data(em_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Tick until ack is seen (bounded); cyc is the number of edges taken.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ack == '0 && cyc < 1000);
    endtask

    int n;
    int cyc;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        id_flat = {ID3, ID2, ID1, ID0};
        tick();
        tick();
        check("rst_em_tx", 64'(em_tx), 64'd0);
        check("rst_em_data", 64'(em_data), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Single request on slot 2
        req = 4'b0100;
        tick();
        check("single_em_data", 64'(em_data), 64'(ID2));
        check("single_grant", 64'(grant_idx), 64'd2);
        check("single_busy", 64'(busy), 64'd1);
        check("single_load_tx0", 64'(em_tx), 64'd0);
        tick();
        check("single_load_tx1", 64'(em_tx), 64'd0);
        tick();
        check("single_tx_rise", 64'(em_tx), 64'd1);
        n = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (em_tx) n++;
            else break;
        end
        check("single_tx_len", 64'(n), 64'(REPEATS * FRAME));
        check("single_ack", 64'(ack), 64'b0100);
        check("single_ack_grant", 64'(grant_idx), 64'd2);
        req = 4'b0000;
        tick();
        check("single_ack_pulse", 64'(ack), 64'd0);
        check("single_idle_busy", 64'(busy), 64'd0);

        // Wrap: ptr is now 3, slots 3 and 0 requesting
        req = 4'b1001;
        tick();
        check("wrap_grant3", 64'(grant_idx), 64'd3);
        check("wrap_data3", 64'(em_data), 64'(ID3));
        wait_ack(cyc);
        check("wrap_ack3", 64'(ack), 64'b1000);
        req = 4'b0001;
        tick();
        tick();
        check("wrap_grant0", 64'(grant_idx), 64'd0);
        check("wrap_data0", 64'(em_data), 64'(ID0));
        wait_ack(cyc);
        check("wrap_ack0", 64'(ack), 64'b0001);
        req = 4'b0000;
        tick();

        // Fairness: all slots requesting from reset
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_ack(cyc);
            check("fair_ack", 64'(ack), 64'(4'b0001 << exp_order[g]));
            check("fair_grant", 64'(grant_idx), 64'(exp_order[g]));
            if (g > 0) check("fair_spacing", 64'(cyc), 64'(ACK_SEP));
        end

        // Abort: slot 1 drops its request 10 cycles into SEND
        req = 4'b0110;
        tick();
        tick();
        check("abort_grant", 64'(grant_idx), 64'd1);
        tick();
        tick();
        check("abort_tx_on", 64'(em_tx), 64'd1);
        for (int i = 0; i < 9; i++) tick();
        req = 4'b0100;
        tick();
        check("abort_tx_off", 64'(em_tx), 64'd0);
        check("abort_no_ack", 64'(ack), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        tick();
        check("abort_next_grant", 64'(grant_idx), 64'd2);
        check("abort_next_data", 64'(em_data), 64'(ID2));
        wait_ack(cyc);
        check("abort_next_ack", 64'(ack), 64'b0100);

        // ID snapshot: slot 0 changes its ID mid-SEND
        req = 4'b0001;
        tick();
        tick();
        check("snap_grant", 64'(grant_idx), 64'd0);
        for (int i = 0; i < 7; i++) tick();
        id_flat[39:0] = ID0_NEW;
        tick();
        check("snap_tx", 64'(em_tx), 64'd1);
        check("snap_data", 64'(em_data), 64'(ID0));

        // Reset mid-SEND, then re-grant with the new ID
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", 64'(em_tx), 64'd0);
        check("rst_mid_data", 64'(em_data), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_grant", 64'(grant_idx), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_regrant_busy", 64'(busy), 64'd1);
        check("rst_regrant_idx", 64'(grant_idx), 64'd0);
        check("rst_regrant_data", 64'(em_data), 64'(ID0_NEW));
        wait_ack(cyc);
        check("rst_regrant_ack", 64'(ack), 64'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
